serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor computing D = A - B, LSB first, one bit per clock.
- Sits downstream of the single-bit full-subtractor cell and drives it: holds operands in shift registers, feeds one bit pair plus the registered borrow to the cell each cycle, and collects the difference bit and borrow.
- Used where area matters more than latency; the result is valid WIDTH+1 cycles after start.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/full_sub_bit.sv | 13 +
 rtl/serial_subtractor.sv | 137 +++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold values 0..width without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one bit per clock.
// Operands are held in shift registers and fed through a single full_sub_bit cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out
);

    localparam int unsigned     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_bor;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    state_t             w_state_nx;
    logic [WIDTH-1:0]   w_a_nx;
    logic [WIDTH-1:0]   w_b_nx;
    logic [WIDTH-1:0]   w_res_nx;
    logic               w_bor_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_busy_nx;
    logic               w_done_nx;
    logic [WIDTH-1:0]   w_d_nx;
    logic               w_bout_nx;

    logic               w_diff;
    logic               w_cell_bout;
    logic [WIDTH-1:0]   w_res_shift;

    full_sub_bit u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_bor),
        .d    (w_diff),
        .bout (w_cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_res_shift = WIDTH'({w_diff, r_res} >> 1);

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_res_nx   = r_res;
        w_bor_nx   = r_bor;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_d_nx     = r_d;
        w_bout_nx  = r_bout;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_a_nx     = A;
                    w_b_nx     = B;
                    w_res_nx   = '0;
                    w_bor_nx   = 1'b0;
                    w_cnt_nx   = '0;
                    w_busy_nx  = 1'b1;
                    w_state_nx = SHIFT;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            SHIFT: begin
                w_a_nx   = r_a >> 1;
                w_b_nx   = r_b >> 1;
                w_res_nx = w_res_shift;
                w_bor_nx = w_cell_bout;
                w_cnt_nx = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_BIT) begin
                    w_d_nx     = w_res_shift;
                    w_bout_nx  = w_cell_bout;
                    w_done_nx  = 1'b1;
                    w_state_nx = DONE;
                end else begin
                    w_busy_nx  = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_res   <= w_res_nx;
            r_bor   <= w_bor_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_d     <= w_d_nx;
            r_bout  <= w_bout_nx;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign D          = r_d;
    assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance and a 1-bit instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, d8;
    logic [0:0] a1, b1, d1;
    logic       busy8, done8, bo8;
    logic       busy1, done1, bo1;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [7:0] d; logic b; } exp8_t;
    typedef struct packed { logic [0:0] d; logic b; } exp1_t;
    exp8_t q8[$];
    exp1_t q1[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .D(d8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .D(d1), .borrow_out(bo1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle on the 8-bit instance; optionally record the expected result.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit track);
        exp8_t e;
        start8 = 1'b1; a8 = a; b8 = b;
        if (track) begin
            e.d = a - b;
            e.b = (a < b);
            q8.push_back(e);
        end
        step();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    // Step until done rises on the selected instance; lat counts cycles since entry.
    task automatic wait_done(input bit w1, output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (((w1 ? done1 : done8) !== 1'b1) && lat < 40) begin
            if ((w1 ? busy1 : busy8) === 1'b1) bcnt++;
            step();
            lat++;
        end
        if (lat >= 40) begin
            checks++; errors++;
            $display("FAIL timeout w1=%0d: no done within %0d cycles", w1, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done8); end
        checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_D got %h want 00", d8); end
        checks++; if (bo8 !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", bo8); end
        checks++; if ({busy1, done1, d1, bo1} !== 4'b0) begin
            errors++; $display("FAIL reset_w1 got %b want 0000", {busy1, done1, d1, bo1});
        end
    endtask

    task automatic test_basic();
        logic [7:0] va [6] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h00, 8'hA5};
        logic [7:0] vb [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h5A};
        int lat, bcnt;
        exp8_t e;
        for (int i = 0; i < 6; i++) begin
            go8(va[i], vb[i], 1'b1);
            wait_done(1'b0, lat, bcnt);
            checks++; if (lat != 8) begin errors++; $display("FAIL basic%0d_latency got %0d want 8", i, lat); end
            checks++; if (bcnt != 8) begin errors++; $display("FAIL basic%0d_busy_cycles got %0d want 8", i, bcnt); end
            checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL basic%0d_busy_in_done got %b want 0", i, busy8); end
            if (q8.size() == 0) begin
                checks++; errors++; $display("FAIL basic%0d_scoreboard empty", i);
            end else begin
                e = q8.pop_front();
                checks++; if (d8 !== e.d) begin errors++; $display("FAIL basic%0d_D got %h want %h", i, d8, e.d); end
                checks++; if (bo8 !== e.b) begin errors++; $display("FAIL basic%0d_borrow got %b want %b", i, bo8, e.b); end
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        int lat, bcnt, ndone;
        exp8_t e;
        logic [7:0] prev_d;
        prev_d = d8;
        go8(8'h10, 8'h01, 1'b1);
        step(); step();
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        step(); step();
        start8 = 1'b0;
        checks++; if (d8 !== prev_d) begin errors++; $display("FAIL ignore_D_hold got %h want %h", d8, prev_d); end
        wait_done(1'b0, lat, bcnt);
        checks++; if (lat != 4) begin errors++; $display("FAIL ignore_latency got %0d want 4", lat); end
        e = q8.pop_front();
        checks++; if ({d8, bo8} !== {e.d, e.b}) begin
            errors++; $display("FAIL ignore_result got %h/%b want %h/%b", d8, bo8, e.d, e.b);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin step(); if (done8 === 1'b1) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL ignore_extra_done got %0d want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        exp8_t e;
        go8(8'h40, 8'h41, 1'b1);
        wait_done(1'b0, lat, bcnt);
        e = q8.pop_front();
        checks++; if ({d8, bo8} !== {e.d, e.b}) begin
            errors++; $display("FAIL b2b_first got %h/%b want %h/%b", d8, bo8, e.d, e.b);
        end
        go8(8'h33, 8'h11, 1'b1);
        checks++; if ({busy8, done8} !== 2'b10) begin
            errors++; $display("FAIL b2b_accept busy/done got %b want 10", {busy8, done8});
        end
        checks++; if (d8 !== e.d) begin errors++; $display("FAIL b2b_D_hold got %h want %h", d8, e.d); end
        wait_done(1'b0, lat, bcnt);
        checks++; if (lat != 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", lat); end
        e = q8.pop_front();
        checks++; if ({d8, bo8} !== {e.d, e.b}) begin
            errors++; $display("FAIL b2b_second got %h/%b want %h/%b", d8, bo8, e.d, e.b);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, ndone;
        exp8_t e;
        go8(8'h77, 8'h12, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({busy8, done8, d8, bo8} !== 11'b0) begin
            errors++; $display("FAIL midrst_outputs got %b/%b/%h/%b want 0/0/00/0", busy8, done8, d8, bo8);
        end
        ndone = 0;
        for (int i = 0; i < 20; i++) begin step(); if (done8 === 1'b1) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        go8(8'h30, 8'h05, 1'b1);
        wait_done(1'b0, lat, bcnt);
        checks++; if (lat != 8) begin errors++; $display("FAIL midrst_latency got %0d want 8", lat); end
        e = q8.pop_front();
        checks++; if ({d8, bo8} !== {e.d, e.b}) begin
            errors++; $display("FAIL midrst_result got %h/%b want %h/%b", d8, bo8, e.d, e.b);
        end
        step();
    endtask

    task automatic test_rst_start_same();
        int nbusy;
        rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        step();
        rst = 1'b0; start8 = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy8 === 1'b1 || done8 === 1'b1) nbusy++;
            step();
        end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL rst_wins activity got %0d want 0", nbusy); end
    endtask

    task automatic test_width1();
        int lat, bcnt;
        exp1_t e, g;
        for (int i = 0; i < 4; i++) begin
            start1 = 1'b1; a1 = 1'(i >> 1); b1 = 1'(i);
            g.d = a1 ^ b1;
            g.b = ~a1[0] & b1[0];
            q1.push_back(g);
            step();
            start1 = 1'b0;
            wait_done(1'b1, lat, bcnt);
            checks++; if (lat != 1) begin errors++; $display("FAIL w1_%0d_latency got %0d want 1", i, lat); end
            e = q1.pop_front();
            checks++; if ({d1, bo1} !== {e.d, e.b}) begin
                errors++; $display("FAIL w1_%0d_result got %b/%b want %b/%b", i, d1, bo1, e.d, e.b);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_rst_start_same();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
